// File: rtl/rr_mux2_arb_if.sv
// Valid/ready bundle between two producers, the arbitrated mux stage and its consumer.
// The slave modport is the arbiter's view; master is the view of the surrounding logic.
interface rr_mux2_arb_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready;
  logic             s;

  modport master (
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, y_valid, y_data, s
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, y_valid, y_data, s
  );
endinterface

// File: rtl/rr_mux2_arb.sv
// Round-robin arbiter with a per-owner burst limit feeding a one-entry output register.
// s exports the current owner with mux convention: 1 selects a, 0 selects b.
module rr_mux2_arb #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input logic         clk,
  input logic         rst_n,
  rr_mux2_arb_if.slave bus
);

  localparam int            CW      = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic {
    OWN_B = 1'b0,
    OWN_A = 1'b1
  } owner_t;

  owner_t           r_owner;
  owner_t           w_ownerNext;
  owner_t           w_winner;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cntNext;
  logic             r_yValid;
  logic             w_yValidNext;
  logic [WIDTH-1:0] r_yData;
  logic [WIDTH-1:0] w_yDataNext;
  logic             w_load;
  logic             w_keepOwner;
  logic             w_grantA;
  logic             w_grantB;

  // On a tie the owner keeps the grant until it has used up its burst allowance.
  always_comb begin
    w_load      = !r_yValid || bus.y_ready;
    w_keepOwner = (r_cnt < BURST_C);
    w_grantA    = 1'b0;
    w_grantB    = 1'b0;
    if (bus.a_valid && bus.b_valid) begin
      if ((r_owner == OWN_A) == w_keepOwner) begin
        w_grantA = 1'b1;
      end else begin
        w_grantB = 1'b1;
      end
    end else begin
      w_grantA = bus.a_valid;
      w_grantB = bus.b_valid;
    end
  end

  assign bus.a_ready = rst_n && w_load && w_grantA;
  assign bus.b_ready = rst_n && w_load && w_grantB;

  always_comb begin
    w_ownerNext  = r_owner;
    w_cntNext    = r_cnt;
    w_yValidNext = r_yValid;
    w_yDataNext  = r_yData;
    w_winner     = w_grantA ? OWN_A : OWN_B;
    if (w_load) begin
      if (w_grantA || w_grantB) begin
        w_yValidNext = 1'b1;
        w_yDataNext  = w_grantA ? bus.a_data : bus.b_data;
        if (w_winner == r_owner) begin
          w_cntNext = (r_cnt >= BURST_C) ? BURST_C : r_cnt + ONE_C;
        end else begin
          w_ownerNext = w_winner;
          w_cntNext   = ONE_C;
        end
      end else begin
        w_yValidNext = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= OWN_B;
      r_cnt    <= '0;
      r_yValid <= 1'b0;
      r_yData  <= '0;
    end else begin
      r_owner  <= w_ownerNext;
      r_cnt    <= w_cntNext;
      r_yValid <= w_yValidNext;
      r_yData  <= w_yDataNext;
    end
  end

  assign bus.y_valid = r_yValid;
  assign bus.y_data  = r_yData;
  assign bus.s       = (r_owner == OWN_A);

endmodule

// File: tb/tb_rr_mux2_arb.sv
// Bench for rr_mux2_arb: two instances (BURST=4 and BURST=1) share one stimulus stream,
// each tracked by its own reference arbiter and expected-data queue.
module tb_rr_mux2_arb;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       yReady;
  logic       aValid [2];
  logic       bValid [2];
  logic [7:0] aData  [2];
  logic [7:0] bData  [2];
  logic       aRdy   [2];
  logic       bRdy   [2];
  logic       yValid [2];
  logic [7:0] yData  [2];
  logic       sOut   [2];
  logic [7:0] aBase;
  logic [7:0] bBase;
  int         nA     [2];
  int         nB     [2];
  bit         takeA  [2];
  bit         takeB  [2];
  int         testsRun = 0;
  int         failCount = 0;

  always #5 clk = ~clk;

  rr_mux2_arb_if #(.WIDTH(WIDTH)) bus4 ();
  rr_mux2_arb_if #(.WIDTH(WIDTH)) bus1 ();

  rr_mux2_arb #(.WIDTH(WIDTH), .BURST(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  rr_mux2_arb #(.WIDTH(WIDTH), .BURST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  assign bus4.a_valid = aValid[0];
  assign bus4.a_data  = aData[0];
  assign bus4.b_valid = bValid[0];
  assign bus4.b_data  = bData[0];
  assign bus4.y_ready = yReady;
  assign bus1.a_valid = aValid[1];
  assign bus1.a_data  = aData[1];
  assign bus1.b_valid = bValid[1];
  assign bus1.b_data  = bData[1];
  assign bus1.y_ready = yReady;

  assign aRdy[0]   = bus4.a_ready;
  assign bRdy[0]   = bus4.b_ready;
  assign yValid[0] = bus4.y_valid;
  assign yData[0]  = bus4.y_data;
  assign sOut[0]   = bus4.s;
  assign aRdy[1]   = bus1.a_ready;
  assign bRdy[1]   = bus1.b_ready;
  assign yValid[1] = bus1.y_valid;
  assign yData[1]  = bus1.y_data;
  assign sOut[1]   = bus1.s;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference arbiter per instance; expected words are queued at grant time and popped on output transfer.
  for (genvar g = 0; g < 2; g++) begin : gMon
    localparam int LIM = (g == 0) ? 4 : 1;
    bit         mOwnA;
    int         mCnt;
    bit         mYV;
    bit         load;
    bit         ga;
    bit         gb;
    logic [7:0] expQ [$];
    logic [7:0] seen [$];

    always @(negedge clk) begin
      if (!rst_n) begin
        mOwnA = 1'b0;
        mCnt  = 0;
        mYV   = 1'b0;
        expQ.delete();
        checkOutput($sformatf("rstYValid%0d", g), yValid[g], 0);
        checkOutput($sformatf("rstYData%0d", g), yData[g], 0);
        checkOutput($sformatf("rstS%0d", g), sOut[g], 0);
        checkOutput($sformatf("rstARdy%0d", g), aRdy[g], 0);
        checkOutput($sformatf("rstBRdy%0d", g), bRdy[g], 0);
      end else begin
        checkOutput($sformatf("yValid%0d", g), yValid[g], mYV);
        checkOutput($sformatf("s%0d", g), sOut[g], mOwnA);
        if (mYV) begin
          if (expQ.size() == 0) begin
            checkOutput($sformatf("yQueueDepth%0d", g), expQ.size(), 1);
          end else begin
            checkOutput($sformatf("yData%0d", g), yData[g], expQ[0]);
            if (yReady) begin
              seen.push_back(yData[g]);
              void'(expQ.pop_front());
            end
          end
        end
        load = !mYV || yReady;
        if (aValid[g] && bValid[g]) begin
          ga = mOwnA ? (mCnt < LIM) : (mCnt >= LIM);
          gb = !ga;
        end else begin
          ga = aValid[g];
          gb = bValid[g];
        end
        checkOutput($sformatf("aReady%0d", g), aRdy[g], load && ga);
        checkOutput($sformatf("bReady%0d", g), bRdy[g], load && gb);
        if (load) begin
          if (ga || gb) begin
            expQ.push_back(ga ? aData[g] : bData[g]);
            mYV = 1'b1;
            if (ga == mOwnA) begin
              mCnt = (mCnt < LIM) ? mCnt + 1 : LIM;
            end else begin
              mOwnA = ga;
              mCnt  = 1;
            end
          end else begin
            mYV = 1'b0;
          end
        end
      end
    end
  end

  task automatic setInputs(input bit aV, input bit bV, input bit yR);
    for (int k = 0; k < 2; k++) begin
      aValid[k] = aV;
      bValid[k] = bV;
      aData[k]  = aBase + 8'(nA[k]);
      bData[k]  = bBase + 8'(nB[k]);
    end
    yReady = yR;
  endtask

  // Sources hold their word until accepted, then advance to the next one.
  task automatic applyStimulus(input bit aV, input bit bV, input bit yR, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      setInputs(aV, bV, yR);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        takeA[k] = aValid[k] && aRdy[k];
        takeB[k] = bValid[k] && bRdy[k];
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (takeA[k]) nA[k]++;
        if (takeB[k]) nB[k]++;
      end
    end
  endtask

  task automatic resetSources(input logic [7:0] aB, input logic [7:0] bB);
    aBase = aB;
    bBase = bB;
    for (int k = 0; k < 2; k++) begin
      nA[k] = 0;
      nB[k] = 0;
    end
    gMon[0].seen.delete();
    gMon[1].seen.delete();
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] expWord;
    int         grp;
    aBase = 8'h00;
    bBase = 8'h00;
    resetSources(8'h00, 8'h00);
    setInputs(1'b1, 1'b1, 1'b1);

    // Reset held with both sources requesting.
    applyStimulus(1'b1, 1'b1, 1'b1, 3);
    #1;
    rst_n = 1'b1;

    // Single channel a streaming 0x01..0x06.
    resetSources(8'h01, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 6);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    checkOutput("singleCount", gMon[0].seen.size(), 6);
    for (int i = 0; i < 6 && i < gMon[0].seen.size(); i++)
      checkOutput($sformatf("singleSeq%0d", i), gMon[0].seen[i], 8'h01 + 8'(i));

    // Continuous contention from a fresh reset.
    pulseReset();
    resetSources(8'hA0, 8'hB0);
    applyStimulus(1'b1, 1'b1, 1'b1, 12);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    checkOutput("contCount4", gMon[0].seen.size(), 12);
    checkOutput("contCount1", gMon[1].seen.size(), 12);
    for (int i = 0; i < 12 && i < gMon[0].seen.size(); i++) begin
      grp     = i / 4;
      expWord = ((grp % 2) == 0 ? 8'hB0 : 8'hA0) + 8'((grp / 2) * 4 + i % 4);
      checkOutput($sformatf("contSeqB4_%0d", i), gMon[0].seen[i], expWord);
    end
    for (int i = 0; i < 12 && i < gMon[1].seen.size(); i++) begin
      expWord = ((i % 2) == 0 ? 8'hB0 : 8'hA0) + 8'(i / 2);
      checkOutput($sformatf("contSeqB1_%0d", i), gMon[1].seen[i], expWord);
    end

    // Backpressure: 0x55 parked with y_ready low for three cycles.
    resetSources(8'h55, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("stallData", yData[0], 8'h55);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("afterStallData", yData[0], 8'h56);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    checkOutput("stallSeqLen", gMon[0].seen.size(), 2);

    // Asynchronous reset in the middle of an a burst.
    resetSources(8'h30, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 2);
    setInputs(1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncYValid4", yValid[0], 0);
    checkOutput("asyncYValid1", yValid[1], 0);
    checkOutput("asyncS4", sOut[0], 0);
    checkOutput("asyncS1", sOut[1], 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // First tie after reset goes to b.
    resetSources(8'hA0, 8'hB0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    checkOutput("tieCount4", gMon[0].seen.size(), 2);
    checkOutput("tieCount1", gMon[1].seen.size(), 2);
    if (gMon[0].seen.size() > 0) checkOutput("tieFirst4", gMon[0].seen[0], 8'hB0);
    if (gMon[1].seen.size() > 0) checkOutput("tieFirst1", gMon[1].seen[0], 8'hB0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
